// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store front end for a word-wide,
// little-endian data memory. Sub-word stores are read-modify-write.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic        mem_r,
    output logic        mem_w
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state, state_nx;
    logic        l_we, l_signed, l_err;
    logic [1:0]  l_size;
    logic [31:0] l_addr, l_wdata, rbuf;
    logic        acc_err;
    logic [31:0] req_waddr;
    logic [31:0] merged, lane, ext;

    // Acceptance check on the incoming request fields
    always_comb begin
        req_waddr = {req_addr[31:2], 2'b00};
        acc_err   = (req_size == 2'b11)
                  | ((req_size == 2'b01) & req_addr[0])
                  | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                  | (req_waddr >= 32'(MEM_BYTES));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req_valid) begin
                if (acc_err)                            state_nx = RESP;
                else if (!req_we || req_size != 2'b10)  state_nx = RD;
                else                                    state_nx = WR;
            end
            RD:      state_nx = l_we ? WR : RESP;
            WR:      state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request latch on accept, read buffer capture in RD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_we     <= 1'b0;
            l_signed <= 1'b0;
            l_err    <= 1'b0;
            l_size   <= '0;
            l_addr   <= '0;
            l_wdata  <= '0;
            rbuf     <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                l_we     <= req_we;
                l_signed <= req_signed;
                l_err    <= acc_err;
                l_size   <= req_size;
                l_addr   <= req_addr;
                l_wdata  <= req_wdata;
            end
            if (state == RD) rbuf <= mem_dout;
        end
    end

    // Store merge and load lane extraction from the read buffer
    always_comb begin
        merged = rbuf;
        case (l_size)
            2'b00:   merged[{l_addr[1:0], 3'b000} +: 8] = l_wdata[7:0];
            2'b01:   merged[{l_addr[1], 4'b0000} +: 16] = l_wdata[15:0];
            default: merged = l_wdata;
        endcase
        lane = rbuf >> {l_addr[1:0], 3'b000};
        if (l_size == 2'b01) lane = rbuf >> {l_addr[1], 4'b0000};
        case (l_size)
            2'b00:   ext = {{24{l_signed & lane[7]}},  lane[7:0]};
            2'b01:   ext = {{16{l_signed & lane[15]}}, lane[15:0]};
            default: ext = rbuf;
        endcase
    end

    // Moore outputs from registered state and latched request
    always_comb begin
        req_ready  = (state == IDLE);
        mem_r      = (state == RD);
        mem_w      = (state == WR);
        mem_addr   = '0;
        mem_din    = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        if (state == RD || state == WR) mem_addr = {l_addr[31:2], 2'b00};
        if (state == WR) mem_din = merged;
        if (state == RESP) begin
            resp_valid = 1'b1;
            resp_err   = l_err;
            if (!l_we && !l_err) resp_rdata = ext;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_r;
    logic        mem_w;

    logic [31:0] mem [0:255];
    logic        mem_load = 1'b1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.MEM_BYTES(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_r(mem_r), .mem_w(mem_w)
    );

    always #5 clk = ~clk;

    // Data memory: preload while mem_load, otherwise word write on rising edge
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[0] <= 32'h0000_0002;
            mem[1] <= 32'h0000_0001;
        end else if (mem_w) begin
            mem[mem_addr[9:2]] <= mem_din;
        end
    end
    assign mem_dout = mem_r ? mem[mem_addr[9:2]] : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare on every response; check bus idle values
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("rw_exclusive", 32'(mem_r & mem_w), 0);
                if (!mem_r && !mem_w) chk("bus_idle", mem_addr | mem_din, 0);
                if (resp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_resp", 32'(resp_valid), 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("resp_rdata", resp_rdata, e.rdata);
                        chk("resp_err", 32'(resp_err), 32'(e.err));
                    end
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) chk({name, "_ready_timeout"}, 32'(req_ready), 1);
    endtask

    // Issue one request, push its expected response, trace its memory activity
    task automatic do_req(input string name, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input logic [31:0] exp_din);
        exp_t e;
        int   k, lat;
        logic saw_r, saw_w, exp_r, exp_w;
        wait_ready(name);
        req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        e.rdata = exp_rdata; e.err = exp_err;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        saw_r = 1'b0; saw_w = 1'b0; lat = -1;
        for (k = 1; k <= 8; k++) begin
            if (mem_r || mem_w) chk({name, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
            if (mem_w) chk({name, "_mem_din"}, mem_din, exp_din);
            saw_r |= mem_r;
            saw_w |= mem_w;
            if (resp_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        exp_r = !exp_err && (!we || size != 2'b10);
        exp_w = !exp_err && we;
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_saw_rd"}, 32'(saw_r), 32'(exp_r));
        chk({name, "_saw_wr"}, 32'(saw_w), 32'(exp_w));
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_outs", {25'd0, resp_valid, resp_err, mem_r, mem_w,
                         |resp_rdata, |mem_addr, |mem_din}, 0);
        @(posedge clk);
        mem_load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // 1: word load
        do_req("t1_lw0", 1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 32'h0000_0002, 1'b0, 2, 32'h0);
        // 2: byte store via RMW, then word readback
        do_req("t2_sb5", 1'b1, 2'b00, 1'b0, 32'd5, 32'h0000_00AB, 32'h0, 1'b0, 3, 32'h0000_AB01);
        do_req("t2_lw4", 1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 32'h0000_AB01, 1'b0, 2, 32'h0);
        // 3: extension
        do_req("t3_lb5", 1'b0, 2'b00, 1'b1, 32'd5, 32'h0, 32'hFFFF_FFAB, 1'b0, 2, 32'h0);
        do_req("t3_lbu5", 1'b0, 2'b00, 1'b0, 32'd5, 32'h0, 32'h0000_00AB, 1'b0, 2, 32'h0);
        do_req("t3_lh4", 1'b0, 2'b01, 1'b1, 32'd4, 32'h0, 32'hFFFF_AB01, 1'b0, 2, 32'h0);
        do_req("t3_lhu6", 1'b0, 2'b01, 1'b0, 32'd6, 32'h0, 32'h0000_0000, 1'b0, 2, 32'h0);
        // 4: rejected requests
        do_req("t4_lw6", 1'b0, 2'b10, 1'b0, 32'd6, 32'h0, 32'h0, 1'b1, 1, 32'h0);
        do_req("t4_sh3", 1'b1, 2'b01, 1'b0, 32'd3, 32'h1234, 32'h0, 1'b1, 1, 32'h0);
        do_req("t4_sz3", 1'b0, 2'b11, 1'b0, 32'd0, 32'h0, 32'h0, 1'b1, 1, 32'h0);
        do_req("t4_lw1024", 1'b0, 2'b10, 1'b0, 32'd1024, 32'h0, 32'h0, 1'b1, 1, 32'h0);
        do_req("t4_lh1022", 1'b0, 2'b01, 1'b1, 32'd1022, 32'h0, 32'h0, 1'b0, 2, 32'h0);

        // 5: reset during RD of a byte store
        wait_ready("t5");
        req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'd8; req_wdata = 32'h0000_00FF; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("t5_in_rd", 32'(mem_r), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_mem_r", 32'(mem_r), 0);
        chk("t5_rst_ready", 32'(req_ready), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_rst_no_w", 32'(mem_w), 0);
            chk("t5_rst_no_resp", 32'(resp_valid), 0);
        end
        rst_n = 1'b1;
        #1 chk("t5_ready_after", 32'(req_ready), 1);
        do_req("t5_lw8", 1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 32'h0000_0000, 1'b0, 2, 32'h0);

        // 6: back-to-back word stores with req_valid held high
        wait_ready("t6");
        begin
            exp_t e;
            e.rdata = '0; e.err = 1'b0;
            req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
            req_addr = 32'd0; req_wdata = 32'h1122_3344; req_valid = 1'b1;
            exp_q.push_back(e);
            @(posedge clk);
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                case (k)
                    1: begin
                        req_addr = 32'd4; req_wdata = 32'h5566_7788;
                        exp_q.push_back(e);
                        chk("t6_k1_ready", 32'(req_ready), 0);
                        chk("t6_k1_w", 32'(mem_w), 1);
                        chk("t6_k1_din", mem_din, 32'h1122_3344);
                    end
                    2: begin
                        chk("t6_k2_ready", 32'(req_ready), 0);
                        chk("t6_k2_resp", 32'(resp_valid), 1);
                    end
                    3: begin
                        chk("t6_k3_ready", 32'(req_ready), 1);
                        chk("t6_k3_w", 32'(mem_w), 0);
                    end
                    4: begin
                        req_valid = 1'b0;
                        chk("t6_k4_w", 32'(mem_w), 1);
                        chk("t6_k4_addr", mem_addr, 32'd4);
                        chk("t6_k4_din", mem_din, 32'h5566_7788);
                    end
                    default: chk("t6_k5_resp", 32'(resp_valid), 1);
                endcase
            end
        end
        do_req("t6_lw0", 1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 32'h1122_3344, 1'b0, 2, 32'h0);
        do_req("t6_lw4", 1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 32'h5566_7788, 1'b0, 2, 32'h0);

        // Halfword store into upper lane, then readback
        do_req("hs_sh6", 1'b1, 2'b01, 1'b0, 32'd6, 32'h0000_BEEF, 32'h0, 1'b0, 3, 32'hBEEF_7788);
        do_req("hs_lw4", 1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 32'hBEEF_7788, 1'b0, 2, 32'h0);

        @(negedge clk);
        @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the pipeline memory stage and the byte-addressed, little-endian, word-wide data memory.
- Accepts one load/store request at a time over a valid/ready handshake and returns one response per request.
- Byte and halfword stores are done as read-modify-write, because the memory port only writes full 32-bit words.
- Loads are sign- or zero-extended; misaligned or out-of-range requests are rejected without touching memory.

Parameters:
- MEM_BYTES, 1024: data memory size in bytes. An aligned word address >= MEM_BYTES is out of range.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (1 only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  load result, extended; 0 for stores and errors
- resp_err  out  1  request rejected; valid with resp_valid
- mem_addr  out  32  word-aligned address to the data memory
- mem_din  out  32  write word to the data memory
- mem_dout  in  32  read word from the data memory (combinational when mem_r=1)
- mem_r  out  1  memory read enable
- mem_w  out  1  memory write enable; memory writes on the rising edge

Behaviour:
- **Reset:** the FSM is in IDLE. Every output is 0 except req_ready, which is 1. The request latch and the read buffer are cleared.
- **Outputs:** all outputs are Moore outputs decoded from the registered state and latched request. No combinational path exists from req_* to mem_* or resp_*.
- **Handshake:** a request is accepted on a rising edge where state=IDLE and req_valid=1. All req_* fields are latched at that edge, and req_* is ignored in all other states.
- **Response:** the response is not back-pressured. resp_valid is high for exactly one cycle, in RESP.
- **Acceptance check:** error if any of the following holds:
  - size=11
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
  - {addr[31:2],2'b00} >= MEM_BYTES
- **States:**
  - IDLE: req_ready=1. On accept:
    - error -> RESP with err flag set.
    - load, or byte/halfword store -> RD.
    - word store -> WR.
  - RD: mem_r=1, mem_addr={addr[31:2],2'b00}. mem_dout is captured into the read buffer at the edge. Next state: RESP for a load, WR for a store.
  - WR: mem_w=1, same mem_addr, mem_din = merged word. Next state: RESP.
    - Word store: merged word = wdata.
    - Byte store: buffer with byte lane addr[1:0] replaced by wdata[7:0].
    - Halfword store: buffer with lanes {addr[1],1}:{addr[1],0} replaced by wdata[15:0].
  - RESP: resp_valid=1, resp_err = err flag. resp_rdata is the extracted lane:
    - byte: buffer >> (8*addr[1:0]), 8 bits
    - halfword: buffer >> (16*addr[1]), 16 bits
    - word: the full buffer
    - extended per req_signed; forced to 0 for stores and errors.
    Next state: IDLE.
- **Latency (accept edge = N):**

  | Request | Memory activity | RESP cycle |
  |---|---|---|
  | error | none | N+1 |
  | load | RD at N+1 | N+2 |
  | word store | WR at N+1 | N+3 is IDLE; RESP at N+2 |
  | byte/halfword store | RD at N+1, WR at N+2 | N+3 |

- **Throughput:** maximum throughput is one request per 3 cycles for loads and word stores, and one per 4 cycles for sub-word stores.
- **Bus idle values:** mem_addr and mem_din are 0 whenever mem_r=0 and mem_w=0. mem_r and mem_w are never both 1.
- **Errors:** no memory access occurs on any error path.
- **Reset mid-operation:** asynchronous return to IDLE. mem_w and mem_r drop immediately, an in-progress read-modify-write is abandoned, memory is unmodified, and no response is issued.
- **Request held high:** if req_valid stays high across a response, the next request is accepted in the IDLE cycle following RESP.

Test Plan:
1. Memory word0=0x00000002, word4=0x00000001. Word load at addr 0, accepted at edge N -> mem_r=1 in N+1; resp_valid in N+2 with rdata=0x00000002, err=0.
2. Byte store, addr=5, wdata=0x000000AB -> RD at addr 4, then WR with mem_din=0x0000AB01. A following word load at 4 -> 0x0000AB01; resp_valid is at accept+3 for the store.
3. After test 2:
   - signed byte load at addr 5 -> 0xFFFFFFAB
   - unsigned byte load at addr 5 -> 0x000000AB
   - signed halfword load at addr 4 -> 0xFFFFAB01
   - unsigned halfword load at addr 6 -> 0x00000000
4. Each of these -> resp_err=1, rdata=0, resp_valid at N+1, mem_r=mem_w=0 throughout:
   - word load at addr 6
   - halfword store at addr 3
   - size=11
   - word load at addr 1024
5. Drop rst_n during RD of a byte store to addr 8 (wdata=0xFF) -> mem_r goes to 0 immediately, no mem_w pulse, no resp_valid. After release, a word load at 8 -> 0x00000000 and req_ready=1.
6. Hold req_valid=1 with two word stores queued back-to-back (addr 0 = 0x11223344, then addr 4 = 0x55667788) -> req_ready=0 during WR/RESP. The second request is accepted exactly at the IDLE cycle after the first RESP. A subsequent load at 4 -> 0x55667788.
